// File: rtl/umem_pkg.sv
// rtl/umem_pkg.sv - shared types for the unified-memory arbiter
package umem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/umem_arb_pick.sv
// rtl/umem_arb_pick.sv - data-first priority picker with fetch override
module umem_arb_pick
    import umem_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic force_if_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    // Data is older in the pipeline, so it wins unless fetch has been starved.
    always_comb begin
        gnt_valid_o = if_req_i | d_req_i;
        gnt_id_o    = GNT_I;
        if (d_req_i && !(if_req_i && force_if_i)) begin
            gnt_id_o = GNT_D;
        end
    end

endmodule

// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - single-port unified memory arbiter for fetch and data
module umem_arbiter
    import umem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam int unsigned TMO_W    = 8;

    state_e              state_q, state_d;
    logic                win_q, win_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                err_q, err_d;

    logic gnt_valid, gnt_id;
    logic streak_full, tmo_hit;

    assign streak_full = (streak_q == STREAK_W'(MAX_DSTREAK));
    // Compared against TIMEOUT-1 because the counter steps to TIMEOUT in this cycle.
    assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT - 1));

    umem_arb_pick u_pick (
        .if_req_i    (if_req_i),
        .d_req_i     (d_req_i),
        .force_if_i  (streak_full),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    win_d     = gnt_id;
                    mem_req_d = 1'b1;
                    if (gnt_id == GNT_D) begin
                        mem_we_d    = d_we_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        state_d     = BUSY_D;
                        if (if_req_i && !streak_full) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        state_d     = BUSY_I;
                        streak_d    = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                tmo_d = tmo_q + 1'b1;
                // An ack in the timeout cycle still counts as a normal completion.
                if (mem_ack_i || tmo_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_ack_i) begin
                        err_d = 1'b1;
                    end
                    if (state_q == BUSY_D) begin
                        d_rdata_d = (mem_ack_i && !mem_we_q) ? mem_rdata_i : '0;
                    end else begin
                        if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end
                end
            end
            DONE: begin
                tmo_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            win_q       <= GNT_I;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign if_ready_o  = (state_q == DONE) && (win_q == GNT_I);
    assign d_ready_o   = (state_q == DONE) && (win_q == GNT_D);
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o);

endmodule

// File: tb/tb_umem_arbiter.sv
// tb/tb_umem_arbiter.sv - scoreboard bench for umem_arbiter
module tb_umem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stall_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    umem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(255)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    mtx_t        exp_m[$];
    mtx_t        cur_m;
    logic        req_prev = 1'b0;
    int          ack_delay = 2;
    bit          no_ack = 1'b0;
    int          wait_cnt = 0;
    int          lat_i, lat_d, lat_x;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] addr);
        if (addr == 32'h10) return 32'h0050_0093;
        return {16'h1234, addr[15:0]};
    endfunction

    function automatic mtx_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mtx_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    // Memory responder: acks in busy cycle ack_delay unless no_ack is set.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
                wait_cnt++;
                if (!no_ack && wait_cnt == ack_delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_model(mem_addr_o);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops expected results whenever the DUT presents a completion or a new request.
    initial begin
        forever begin
            @(negedge clk_i);
            if (if_ready_o) begin
                if (exp_i.size() == 0) check("unexpected if_ready", 32'd1, 32'd0);
                else check("if_rdata", if_rdata_o, exp_i.pop_front());
            end
            if (d_ready_o) begin
                if (exp_d.size() == 0) check("unexpected d_ready", 32'd1, 32'd0);
                else check("d_rdata", d_rdata_o, exp_d.pop_front());
            end
            if (mem_req_o && !req_prev) begin
                if (exp_m.size() == 0) begin
                    check("unexpected mem_req", 32'd1, 32'd0);
                end else begin
                    cur_m = exp_m.pop_front();
                    check("mem_we", 32'(mem_we_o), 32'(cur_m.we));
                    check("mem_addr", mem_addr_o, cur_m.addr);
                    if (cur_m.we) check("mem_wdata", mem_wdata_o, cur_m.wdata);
                end
            end else if (mem_req_o) begin
                check("mem_we held", 32'(mem_we_o), 32'(cur_m.we));
                check("mem_addr held", mem_addr_o, cur_m.addr);
            end
            req_prev = mem_req_o;
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input logic exp_stall, output int lat);
        bit done = 1'b0;
        lat = 0;
        if_addr_i = addr;
        if_req_i  = 1'b1;
        while (!done) begin
            @(negedge clk_i);
            lat++;
            if (if_ready_o) begin
                check("stall at if_ready", 32'(stall_o), 32'(exp_stall));
                done = 1'b1;
            end else begin
                check("stall fetch pending", 32'(stall_o), 32'd1);
                if (lat > 600) begin
                    check("fetch ready timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        #1;
        if_req_i = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_stall, output int lat);
        bit done = 1'b0;
        lat = 0;
        d_we_i    = we;
        d_addr_i  = addr;
        d_wdata_i = wdata;
        d_req_i   = 1'b1;
        while (!done) begin
            @(negedge clk_i);
            lat++;
            if (d_ready_o) begin
                check("stall at d_ready", 32'(stall_o), 32'(exp_stall));
                done = 1'b1;
            end else begin
                check("stall data pending", 32'(stall_o), 32'd1);
                if (lat > 600) begin
                    check("data ready timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        #1;
        d_req_i = 1'b0;
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    initial begin
        #200000;
        check("watchdog", 32'd0, 32'd1);
        finish_run();
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst mem_req", 32'(mem_req_o), 32'd0);
        check("rst mem_we", 32'(mem_we_o), 32'd0);
        check("rst mem_addr", mem_addr_o, 32'd0);
        check("rst mem_wdata", mem_wdata_o, 32'd0);
        check("rst ready", {30'd0, if_ready_o, d_ready_o}, 32'd0);
        check("rst rdata", if_rdata_o | d_rdata_o, 32'd0);
        check("rst stall/err", {30'd0, stall_o, err_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Fetch only, ack in second busy cycle
        ack_delay = 2;
        exp_m.push_back(mk(1'b0, 32'h10, 32'h0));
        exp_i.push_back(32'h0050_0093);
        do_fetch(32'h10, 1'b0, lat_i);
        check("fetch latency", lat_i, 32'd3);
        @(negedge clk_i);

        // Simultaneous store and fetch: store first
        exp_m.push_back(mk(1'b1, 32'h80, 32'hDEAD_BEEF));
        exp_m.push_back(mk(1'b0, 32'h20, 32'h0));
        exp_d.push_back(32'h0);
        exp_i.push_back(32'h1234_0020);
        fork
            do_data(1'b1, 32'h80, 32'hDEAD_BEEF, 1'b1, lat_d);
            do_fetch(32'h20, 1'b0, lat_i);
        join
        check("store latency", lat_d, 32'd3);
        check("fetch after store latency", lat_i, 32'd7);
        @(negedge clk_i);

        // Data streak with fetch held: four data grants, then fetch, then data resumes
        ack_delay = 1;
        for (int k = 0; k < 4; k++) exp_m.push_back(mk(1'b0, 32'h100 + 32'(4 * k), 32'h0));
        exp_m.push_back(mk(1'b0, 32'h40, 32'h0));
        exp_m.push_back(mk(1'b0, 32'h110, 32'h0));
        exp_m.push_back(mk(1'b0, 32'h114, 32'h0));
        for (int k = 0; k < 6; k++) exp_d.push_back(32'h1234_0100 + 32'(4 * k));
        exp_i.push_back(32'h1234_0040);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    do_data(1'b0, 32'h100 + 32'(4 * k), 32'h0, (k < 4) ? 1'b1 : 1'b0, lat_x);
                end
            end
            do_fetch(32'h40, 1'b1, lat_i);
            begin
                bit seen = 1'b0;
                for (int c = 0; c < 200 && !seen; c++) begin
                    @(negedge clk_i);
                    if (mem_req_o && mem_addr_o == 32'h40) begin
                        check("streak after fetch grant", 32'(dut.streak_q), 32'd0);
                        seen = 1'b1;
                    end
                end
                if (!seen) check("fetch grant seen", 32'd0, 32'd1);
            end
        join
        @(negedge clk_i);

        // Minimum round trip
        exp_m.push_back(mk(1'b0, 32'h200, 32'h0));
        exp_d.push_back(32'h1234_0200);
        do_data(1'b0, 32'h200, 32'h0, 1'b0, lat_d);
        check("min round trip", lat_d, 32'd2);
        @(negedge clk_i);

        // Ack coincides with timeout: normal completion
        ack_delay = 255;
        exp_m.push_back(mk(1'b0, 32'h300, 32'h0));
        exp_d.push_back(32'h1234_0300);
        do_data(1'b0, 32'h300, 32'h0, 1'b0, lat_d);
        check("ack-at-timeout latency", lat_d, 32'd256);
        check("err after late ack", 32'(err_o), 32'd0);
        repeat (3) @(negedge clk_i);
        check("d_rdata held", d_rdata_o, 32'h1234_0300);

        // No ack: timeout aborts with zero data and sticky error
        no_ack = 1'b1;
        exp_m.push_back(mk(1'b0, 32'h304, 32'h0));
        exp_d.push_back(32'h0);
        do_data(1'b0, 32'h304, 32'h0, 1'b0, lat_d);
        check("timeout latency", lat_d, 32'd256);
        check("err after timeout", 32'(err_o), 32'd1);
        no_ack = 1'b0;
        ack_delay = 1;
        @(negedge clk_i);
        exp_m.push_back(mk(1'b0, 32'h308, 32'h0));
        exp_d.push_back(32'h1234_0308);
        do_data(1'b0, 32'h308, 32'h0, 1'b0, lat_d);
        check("err sticky", 32'(err_o), 32'd1);
        check("if_rdata held", if_rdata_o, 32'h1234_0040);
        @(negedge clk_i);

        // Reset during BUSY_D
        no_ack = 1'b1;
        exp_m.push_back(mk(1'b0, 32'h400, 32'h0));
        d_we_i = 1'b0; d_addr_i = 32'h400; d_req_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("busy before reset", 32'(mem_req_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check("mem_req async drop", 32'(mem_req_o), 32'd0);
        check("err cleared by reset", 32'(err_o), 32'd0);
        d_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        no_ack = 1'b0;
        ack_delay = 2;
        @(negedge clk_i);
        exp_m.push_back(mk(1'b0, 32'h30, 32'h0));
        exp_i.push_back(32'h1234_0030);
        do_fetch(32'h30, 1'b0, lat_i);
        check("fetch after reset latency", lat_i, 32'd3);

        repeat (3) @(negedge clk_i);
        check("scoreboard drained", 32'(exp_i.size() + exp_d.size() + exp_m.size()), 32'd0);
        finish_run();
    end

endmodule
